// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop decode into a one-byte valid/ready holding register.
// Define UART_RX_SYNC_EN to put rx_pin through a 2-flop synchronizer (needed for asynchronous sources).
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  // Both stages reset to the idle level so reset release never looks like a start edge.
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_pin};
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_pin;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   deliver;
  logic                   accept;

  assign accept = valid_q && rx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        // Mid start bit: a line already back high was a glitch.
        if (cnt_q == HALF_M1) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver && (!valid_q || accept)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged on rx_pin, expected bytes go to a scoreboard queue.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 155;
`else
  localparam int LAT = 153;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int n_valid_cyc = 0, n_fe = 0, n_ov = 0, n_acc = 0;
  int valid_rise_cyc = -1, ov_cyc = -1;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (rx_valid) n_valid_cyc++;
      if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
      valid_prev = rx_valid;
      if (frame_err) n_fe++;
      if (overrun) begin
        n_ov++;
        ov_cyc = cyc;
      end
      if (rx_valid && rx_ready) begin
        n_acc++;
        if (exp_q.size() == 0) check("sb_unexpected", int'(rx_data), -1);
        else                   check("sb_byte", int'(rx_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    tick(CPB);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int fall);
    fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  initial begin
    int f, f2, v0, fe0, a0;
    logic [7:0] b;
    tick(3);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;
    tick(4);

    // 1: single byte, consumer ready
    rx_ready = 1'b1;
    v0 = n_valid_cyc;
    exp_q.push_back(8'h54);
    send(8'h54, 1'b1, f);
    tick(2);
    check("t1_latency", valid_rise_cyc - f, LAT);
    check("t1_valid_cycles", n_valid_cyc - v0, 1);
    check("t1_no_flags", n_fe + n_ov, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: back-to-back frames, consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h0D);
    send(8'h0D, 1'b1, f);
    send(8'h0A, 1'b1, f2);
    tick(4);
    check("t2_valid_held", rx_valid, 1);
    check("t2_data_held", rx_data, 8'h0D);
    check("t2_overrun_cnt", n_ov, 1);
    check("t2_overrun_time", ov_cyc - f2, LAT);
    a0 = n_acc;
    rx_ready = 1'b1;
    tick(3);
    check("t2_one_accept", n_acc - a0, 1);
    check("t2_valid_drop", rx_valid, 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: short low glitch rejected
    v0 = n_valid_cyc;
    rx_pin = 1'b0;
    tick(5);
    rx_pin = 1'b1;
    tick(3 * CPB);
    check("t3_no_valid", n_valid_cyc - v0, 0);
    check("t3_no_fe", n_fe, 0);
    exp_q.push_back(8'h41);
    send(8'h41, 1'b1, f);
    tick(2);
    check("t3_next_byte", n_valid_cyc - v0, 1);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: framing error then held break
    v0 = n_valid_cyc;
    fe0 = n_fe;
    send(8'h55, 1'b0, f);
    tick(40 * CPB);
    check("t4_fe_pulse", n_fe - fe0, 1);
    check("t4_no_valid", n_valid_cyc - v0, 0);
    rx_pin = 1'b1;
    tick(CPB);
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, f);
    tick(2);
    check("t4_recover", n_valid_cyc - v0, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // 5: reset mid-frame, released with line low
    b = 8'h6E;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx_pin = b[3];
    tick(CPB / 2);
    reset = 1'b1;
    rx_pin = 1'b0;
    tick(3);
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_data", rx_data, 0);
    check("t5_rst_flags", {30'd0, frame_err, overrun}, 0);
`ifdef UART_RX_SYNC_EN
    rx_pin = 1'b1;
`endif
    reset = 1'b0;
    v0 = n_valid_cyc;
    fe0 = n_fe;
    tick(3 * CPB);
    check("t5_no_decode", n_valid_cyc - v0, 0);
    check("t5_no_fe", n_fe - fe0, 0);
    rx_pin = 1'b1;
    tick(CPB);
    exp_q.push_back(8'h32);
    send(8'h32, 1'b1, f);
    tick(2);
    check("t5_next_byte", n_valid_cyc - v0, 1);
    check("t5_sb_empty", exp_q.size(), 0);
    check("t5_flags_after", n_fe - fe0, 0);

    check("total_overrun", n_ov, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
